// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow error flags and an optional
// first-word-fall-through read mode.
//
// Optional feature macro: SYNC_FIFO_FWFT_EN
//   undefined : standard mode, rd_data is registered (1-cycle read latency),
//               reset to 0, holds its value when no read is accepted.
//   defined   : first-word-fall-through, rd_data is a combinational view of
//               the head entry, valid whenever empty=0; rd_en pops it.
//
// Parameters:
//   DATA_W   data word width (>=1)
//   DEPTH    number of entries, power of two, >=4
//   AF_LEVEL almost_full asserts when count >= AF_LEVEL
//   AE_LEVEL almost_empty asserts when count <= AE_LEVEL
//   CNT_W    (local) width of count, $clog2(DEPTH)+1
//
// Ports:
//   clk           clock, all logic on rising edge
//   rst_n         synchronous active-low reset
//   wr_en/wr_data write request and data
//   rd_en/rd_data read request and data
//   full, empty, almost_full, almost_empty   occupancy flags
//   count         current occupancy 0..DEPTH
//   err_clr       clears overflow/underflow (a new error in the same cycle wins)
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
// ---------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg,  count_next;
    logic             overflow_reg,  overflow_next;
    logic             underflow_reg, underflow_next;

    logic wr_ok;
    logic rd_ok;

    // Flags decode the registered count directly, so they never lag it.
    assign empty        = (count_reg == '0);
    assign full         = (count_reg == CNT_W'(DEPTH));
    assign almost_full  = (count_reg >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count_reg <= CNT_W'(AE_LEVEL));
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a
    // write when it is also being read.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        if (wr_ok) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end

        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase

        // Clear first, then set, so a new error in the clear cycle survives.
        if (err_clr) begin
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end
        if (wr_en && !wr_ok) begin
            overflow_next = 1'b1;
        end
        if (rd_en && !rd_ok) begin
            underflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage is deliberately not reset so it maps onto block RAM; writes
    // are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry shown combinationally; content is meaningless while empty.
    assign rd_data = mem[rd_ptr_reg];
`else
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (rd_ok) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

    assign rd_data = rd_data_reg;
`endif

endmodule
